// File: rtl/exec_stage_if.sv
// exec_stage_if: upstream, ALU and writeback handshake bundle of the execute stage.
interface exec_stage_if #(parameter int WIDTH = 32, parameter int RD_BITS = 5);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [7:0]         in_op;
  logic [RD_BITS-1:0] in_rd;
  logic               in_sel_extra;
  logic               alu_valid;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [7:0]         alu_op;
  logic               alu_ready;
  logic [WIDTH-1:0]   alu_result;
  logic [WIDTH-1:0]   alu_extra_result;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [RD_BITS-1:0] out_rd;
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_rd, in_sel_extra,
    input  alu_ready, alu_result, alu_extra_result, out_ready,
    output in_ready, alu_valid, alu_a, alu_b, alu_op, out_valid, out_data, out_rd
  );
  modport master (
    output in_valid, in_a, in_b, in_op, in_rd, in_sel_extra,
    output alu_ready, alu_result, alu_extra_result, out_ready,
    input  in_ready, alu_valid, alu_a, alu_b, alu_op, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: IDLE/BUSY/DONE sequencer between decode, a shared ALU and writeback.
// Define EXEC_STAGE_PERF_EN to add the stall_cycles counter port.
module exec_stage #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
`ifdef EXEC_STAGE_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  exec_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic [7:0]         op_q, op_d;
  logic [RD_BITS-1:0] rd_q, rd_d, out_rd_q, out_rd_d;
  logic               sel_q, sel_d;
  logic               in_ready, accept;
  assign in_ready      = !flush && (state_q == IDLE || (state_q == DONE && bus.out_ready));
  assign accept        = in_ready && bus.in_valid;
  assign bus.in_ready  = in_ready;
  assign bus.alu_valid = state_q == BUSY;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data  = data_q;
  assign bus.out_rd    = out_rd_q;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sel_d    = sel_q;
    data_d   = data_q;
    out_rd_d = out_rd_q;
    if (accept) begin
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      op_d    = bus.in_op;
      rd_d    = bus.in_rd;
      sel_d   = bus.in_sel_extra;
      state_d = BUSY;
    end else if (state_q == BUSY && bus.alu_ready) begin
      // x0 is hardwired to zero, but the writeback handshake still happens
      data_d   = (rd_q == '0) ? '0 : (sel_q ? bus.alu_extra_result : bus.alu_result);
      out_rd_d = rd_q;
      state_d  = DONE;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sel_q    <= 1'b0;
      data_q   <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      out_rd_q <= out_rd_d;
    end
  end
`ifdef EXEC_STAGE_PERF_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d      = stall_q + 32'((state_q == BUSY && !bus.alu_ready) || (state_q == DONE && !bus.out_ready));
  assign stall_cycles = stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule
